// File: rtl/dot_engine_if.sv
// Bus between the dot-product engine and its upstream/downstream neighbours.
// Carries the control pulse, the operand beat stream and the result handshake.
interface dot_engine_if #(
  parameter int P_WIDTH     = 32,
  parameter int P_LANES     = 4,
  parameter int P_ACC_WIDTH = 64,
  parameter int P_LEN_WIDTH = 16
) ();
  logic                         start;
  logic [P_LEN_WIDTH-1:0]       len;
  logic                         in_valid;
  logic                         in_ready;
  logic [P_LANES*P_WIDTH-1:0]   in_a;
  logic [P_LANES*P_WIDTH-1:0]   in_b;
  logic                         out_valid;
  logic                         out_ready;
  logic [P_ACC_WIDTH-1:0]       out;
  logic                         busy;

  // Upstream/downstream side: launches vectors, streams beats, takes results.
  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  // Engine side.
  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/dot_engine.sv
// Multi-lane pipelined dot-product engine.
// Stage 1 registers per-lane products, stage 2 registers their sum, and the
// accumulator absorbs the sum one edge later (beat at t lands at t+2).

// One multiplier lane: registers the full-width unsigned product of a beat.
module dot_lane #(
  parameter int P_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [P_WIDTH-1:0]     a_i,
  input  logic [P_WIDTH-1:0]     b_i,
  output logic [2*P_WIDTH-1:0]   prod_o
);
  localparam int PW2 = 2 * P_WIDTH;

  logic [PW2-1:0] prod_q;

  // Capture the product only for accepted beats; the valid bit travels separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prod_q <= '0;
    else if (en_i) prod_q <= PW2'(a_i) * PW2'(b_i);
  end

  assign prod_o = prod_q;
endmodule

module dot_engine #(
  parameter int P_WIDTH     = 32,
  parameter int P_LANES     = 4,
  parameter int P_ACC_WIDTH = 64,
  parameter int P_LEN_WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  dot_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [P_LEN_WIDTH-1:0]             cnt_q, cnt_d;
  logic [P_ACC_WIDTH-1:0]             acc_q;
  logic [P_ACC_WIDTH-1:0]             sum_q;
  logic [P_ACC_WIDTH-1:0]             lane_sum;
  logic [P_ACC_WIDTH-1:0]             out_q;
  logic [1:0]                         vld_pipe_q;
  logic [P_LANES-1:0][2*P_WIDTH-1:0]  prod;
  logic                               accept;
  logic                               acc_clr;
  logic                               out_ld;
  logic                               out_zero;

  assign accept = bus.in_valid && (state_q == ACCUM);

  genvar gi;
  generate
    for (gi = 0; gi < P_LANES; gi++) begin : g_lane
      dot_lane #(.P_WIDTH(P_WIDTH)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .a_i    (bus.in_a[gi*P_WIDTH +: P_WIDTH]),
        .b_i    (bus.in_b[gi*P_WIDTH +: P_WIDTH]),
        .prod_o (prod[gi])
      );
    end
  endgenerate

  // Zero-extend each lane product and add them into one accumulator-width value.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < P_LANES; i++) lane_sum = lane_sum + P_ACC_WIDTH'(prod[i]);
  end

  // Valid shift register: [0] products held, [1] lane-sum held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= {vld_pipe_q[0], accept};
  end

  // Stage-2 sum register; only loaded when stage 1 holds a real beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                sum_q <= '0;
    else if (vld_pipe_q[0]) sum_q <= lane_sum;
  end

  // Accumulator: cleared on vector launch, wraps silently on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                acc_q <= '0;
    else if (acc_clr)       acc_q <= '0;
    else if (vld_pipe_q[1]) acc_q <= acc_q + sum_q;
  end

  // Result register: stays put through DONE so back-pressure sees a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_q <= '0;
    else if (out_zero) out_q <= '0;
    else if (out_ld)   out_q <= acc_q;
  end

  // State and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter only decrements, so len at its maximum is safe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_clr  = 1'b0;
    out_ld   = 1'b0;
    out_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            cnt_d   = bus.len;
            acc_clr = 1'b1;
            state_d = ACCUM;
          end else begin
            out_zero = 1'b1;
            state_d  = DONE;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == P_LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Both pipeline stages empty means the last beat is in the accumulator.
        if (vld_pipe_q == 2'b00) begin
          out_ld  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
endmodule

// File: tb/tb_dot_engine.sv
// Directed bench for dot_engine with 8-bit operands, 4 lanes, 32-bit accumulator.
module tb_dot_engine;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int AW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dot_engine_if #(.P_WIDTH(W), .P_LANES(L), .P_ACC_WIDTH(AW), .P_LEN_WIDTH(LW)) bus ();

  dot_engine #(.P_WIDTH(W), .P_LANES(L), .P_ACC_WIDTH(AW), .P_LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Wait for out_valid at negedges, up to a cycle budget.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Complete the result handshake in one cycle.
  task automatic ack();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Launch a one-beat vector and leave the engine draining.
  task automatic one_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    bus.start = 1'b1; bus.len = 16'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out !== 32'd0)      begin n_err++; $display("FAIL reset_out got %0d want 0", bus.out); end
    n_vec++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    bus.start = 1'b1; bus.len = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_accum in_ready=%b busy=%b want 1 1", bus.in_ready, bus.busy); end
    bus.in_valid = 1'b1;
    bus.in_a = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.in_b = {8'd8, 8'd7, 8'd6, 8'd5};
    @(negedge clk);
    bus.in_a = {4{8'd2}};
    bus.in_b = {4{8'd2}};
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_drop got %b want 0", bus.in_ready); end
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.out_valid === 1'b1 && lat == 0) lat = k;
    end
    n_vec++; if (lat != 4)          begin n_err++; $display("FAIL basic_latency got %0d edges want 3", lat - 1); end
    n_vec++; if (bus.out !== 32'd86) begin n_err++; $display("FAIL basic_out got %0d want 86", bus.out); end
    ack();
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_bubbles();
    bit ok;
    bus.start = 1'b1; bus.len = 16'd3;
    bus.in_a = {4{8'hFF}}; bus.in_b = {4{8'hFF}};
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b0;
    // in_valid keeps toggling after the third beat; those must be ignored.
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    bus.in_valid = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL bubbles_timeout out_valid=%b want 1", bus.out_valid); end
    n_vec++; if (bus.out !== 32'd780300) begin n_err++; $display("FAIL bubbles_out got %0d want 780300", bus.out); end
    ack();
  endtask

  task automatic test_empty();
    bus.start = 1'b1; bus.len = 16'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL empty_out_valid got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out !== 32'd0)      begin n_err++; $display("FAIL empty_out got %0d want 0", bus.out); end
    n_vec++; if (bus.in_ready !== 1'b0)  begin n_err++; $display("FAIL empty_in_ready got %b want 0", bus.in_ready); end
    ack();
  endtask

  task automatic test_back_pressure();
    bit ok;
    one_beat({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}});
    wait_valid(10, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout out_valid=%b want 1", bus.out_valid); end
    for (int k = 0; k < 10; k++) begin
      bus.start = 1'b1; bus.len = 16'd5;
      @(negedge clk);
      n_vec++;
      if (bus.out !== 32'd10 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
        n_err++; $display("FAIL bp_hold cycle %0d out=%0d valid=%b busy=%b want 10 1 1", k, bus.out, bus.out_valid, bus.busy);
      end
    end
    // start coincides with the handshake and must be dropped.
    bus.start = 1'b1; bus.len = 16'd3; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored busy=%b want 0", bus.busy); end
    one_beat({4{8'd2}}, {4{8'd2}});
    wait_valid(10, ok);
    n_vec++; if (!ok || bus.out !== 32'd16) begin n_err++; $display("FAIL bp_next_vector got %0d valid=%b want 16 1", bus.out, ok); end
    ack();
  endtask

  task automatic test_wrap();
    bit ok;
    bus.start = 1'b1; bus.len = 16'd20000;
    bus.in_a = {4{8'hFF}}; bus.in_b = {4{8'hFF}};
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(20100, ok);
    bus.in_valid = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_timeout out_valid=%b want 1", bus.out_valid); end
    n_vec++; if (bus.out !== 32'd907032704) begin n_err++; $display("FAIL wrap_out got %0d want 907032704", bus.out); end
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    bus.start = 1'b1; bus.len = 16'd4;
    bus.in_a = {4{8'd1}}; bus.in_b = {4{8'd1}};
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 32'd0) begin
      n_err++; $display("FAIL rst_async in_ready=%b out_valid=%b busy=%b out=%0d want 0 0 0 0", bus.in_ready, bus.out_valid, bus.busy, bus.out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL rst_no_result out_valid seen=1 want 0"); end
    one_beat({4{8'd1}}, {4{8'd1}});
    wait_valid(10, ok);
    n_vec++; if (!ok || bus.out !== 32'd4) begin n_err++; $display("FAIL rst_next_vector got %0d valid=%b want 4 1", bus.out, ok); end
    ack();
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_empty();
    test_back_pressure();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
